alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the RV32I/M datapath: single-cycle integer ops plus iterative mul/div.

---
 rtl/alu_mc.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/M ALU with valid/ready handshakes on operands and result.
// Define ALU_MULDIV_EN to build the iterative radix-2 multiply/divide unit (opcodes 16-23).
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Zero
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_LUI    = OPW'(5'd0);
    localparam logic [OPW-1:0] OP_ADD    = OPW'(5'd1);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(5'd2);
    localparam logic [OPW-1:0] OP_XOR    = OPW'(5'd3);
    localparam logic [OPW-1:0] OP_OR     = OPW'(5'd4);
    localparam logic [OPW-1:0] OP_AND    = OPW'(5'd5);
    localparam logic [OPW-1:0] OP_SLL    = OPW'(5'd6);
    localparam logic [OPW-1:0] OP_SRL    = OPW'(5'd7);
    localparam logic [OPW-1:0] OP_SRA    = OPW'(5'd8);
    localparam logic [OPW-1:0] OP_SLT    = OPW'(5'd9);
    localparam logic [OPW-1:0] OP_SLTU   = OPW'(5'd10);
`ifdef ALU_MULDIV_EN
    localparam logic [OPW-1:0] OP_MUL    = OPW'(5'd16);
    localparam logic [OPW-1:0] OP_MULH   = OPW'(5'd17);
    localparam logic [OPW-1:0] OP_MULHSU = OPW'(5'd18);
    localparam logic [OPW-1:0] OP_MULHU  = OPW'(5'd19);
    localparam logic [OPW-1:0] OP_DIV    = OPW'(5'd20);
    localparam logic [OPW-1:0] OP_DIVU   = OPW'(5'd21);
    localparam logic [OPW-1:0] OP_REM    = OPW'(5'd22);
    localparam logic [OPW-1:0] OP_REMU   = OPW'(5'd23);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`endif

    function automatic logic [WIDTH-1:0] simple_result(input logic [OPW-1:0] op,
                                                       input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic [SHW-1:0]   shamt;
        logic [WIDTH-1:0] res;
        shamt = b[SHW-1:0];
        case (op)
            OP_LUI:  res = b;
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_XOR:  res = a ^ b;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $signed(a) >>> shamt;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: res = a;
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    state_t           accept_st_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             load_simple_s;
    logic [WIDTH-1:0] simple_s;
    logic [WIDTH-1:0] c_r;
    logic             zero_r;

`ifdef ALU_MULDIV_EN
    logic               is_md_s;
    logic               is_div_s;
    logic               a_signed_s;
    logic               b_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               md_finish_s;
    logic [WIDTH-1:0]   md_result_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic               is_div_r;

    logic [OPW-1:0]     op_r;
    logic [WIDTH-1:0]   a_r;
    logic [CNTW-1:0]    cnt_r;
    logic               neg_r;
    logic               rneg_r;
    logic               bzero_r;
    // Mul: acc_hi_r/acc_lo_r form the running product, addend_r is the multiplicand.
    // Div: acc_hi_r is the partial remainder, acc_lo_r the dividend/quotient, addend_r the divisor.
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [WIDTH-1:0]   addend_r;

    assign is_md_s       = (ALUOp >= OP_MUL) && (ALUOp <= OP_REMU);
    assign is_div_s      = (ALUOp >= OP_DIV);
    assign a_signed_s    = (ALUOp == OP_MULH) || (ALUOp == OP_MULHSU) ||
                           (ALUOp == OP_DIV)  || (ALUOp == OP_REM);
    assign b_signed_s    = (ALUOp == OP_MULH) || (ALUOp == OP_DIV) || (ALUOp == OP_REM);
    assign a_neg_s       = a_signed_s && A[WIDTH-1];
    assign b_neg_s       = b_signed_s && B[WIDTH-1];
    assign mag_a_s       = a_neg_s ? -A : A;
    assign mag_b_s       = b_neg_s ? -B : B;
    assign accept_st_s   = is_md_s ? ST_BUSY : ST_DONE;
    assign load_simple_s = accept_s && !is_md_s;
    assign md_finish_s   = (state_r == ST_BUSY) && (cnt_r == {CNTW{1'b0}});
    assign is_div_r      = (op_r >= OP_DIV);

    assign mul_sum_s   = {1'b0, acc_hi_r} +
                         (acc_lo_r[0] ? {1'b0, addend_r} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, addend_r};

    // Sign fix-up and divide-by-zero handling once the magnitude iteration is complete.
    always_comb begin
        prod_s     = {acc_hi_r, acc_lo_r};
        prod_fix_s = neg_r ? -prod_s : prod_s;
        quo_fix_s  = neg_r ? -acc_lo_r : acc_lo_r;
        rem_fix_s  = rneg_r ? -acc_hi_r : acc_hi_r;
        case (op_r)
            OP_MUL:    md_result_s = prod_fix_s[WIDTH-1:0];
            OP_MULH:   md_result_s = prod_fix_s[2*WIDTH-1:WIDTH];
            OP_MULHSU: md_result_s = prod_fix_s[2*WIDTH-1:WIDTH];
            OP_MULHU:  md_result_s = prod_fix_s[2*WIDTH-1:WIDTH];
            OP_DIV:    md_result_s = bzero_r ? {WIDTH{1'b1}} : quo_fix_s;
            OP_DIVU:   md_result_s = bzero_r ? {WIDTH{1'b1}} : acc_lo_r;
            OP_REM:    md_result_s = bzero_r ? a_r : rem_fix_s;
            OP_REMU:   md_result_s = bzero_r ? a_r : acc_hi_r;
            default:   md_result_s = a_r;
        endcase
    end

    // Iterative mul/div datapath: load magnitudes at accept, then one bit per BUSY cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_r     <= {OPW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            cnt_r    <= {CNTW{1'b0}};
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            bzero_r  <= 1'b0;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            addend_r <= {WIDTH{1'b0}};
        end else if (accept_s && is_md_s) begin
            op_r     <= ALUOp;
            a_r      <= A;
            cnt_r    <= CNTW'(WIDTH);
            neg_r    <= a_neg_s ^ b_neg_s;
            rneg_r   <= a_neg_s;
            bzero_r  <= (B == {WIDTH{1'b0}});
            acc_hi_r <= {WIDTH{1'b0}};
            if (is_div_s) begin
                addend_r <= mag_b_s;
                acc_lo_r <= mag_a_s;
            end else begin
                addend_r <= mag_a_s;
                acc_lo_r <= mag_b_s;
            end
        end else if ((state_r == ST_BUSY) && (cnt_r != {CNTW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNTW-1){1'b0}}, 1'b1};
            if (!is_div_r) begin
                acc_hi_r <= mul_sum_s[WIDTH:1];
                acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
            end else if (!div_diff_s[WIDTH]) begin
                acc_hi_r <= div_diff_s[WIDTH-1:0];
                acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_r <= div_shift_s[WIDTH-1:0];
                acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    assign accept_st_s   = ST_DONE;
    assign load_simple_s = accept_s;
`endif

    assign simple_s = simple_result(ALUOp, A, B);

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and acceptance logic; a consumed result may be replaced on the same edge.
    always_comb begin
        state_nx_s = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_nx_s = accept_st_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            ST_BUSY: begin
                if (cnt_r == {CNTW{1'b0}}) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
`endif
            ST_DONE: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    state_nx_s = accept_st_s;
                end else if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign accept_s = in_valid && in_ready_s;

    // Result and Zero flag: simple ops load at accept, mul/div when the iteration ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_r    <= {WIDTH{1'b0}};
            zero_r <= 1'b0;
        end else if (load_simple_s) begin
            c_r    <= simple_s;
            zero_r <= (simple_s == {WIDTH{1'b0}});
`ifdef ALU_MULDIV_EN
        end else if (md_finish_s) begin
            c_r    <= md_result_s;
            zero_r <= (md_result_s == {WIDTH{1'b0}});
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_DONE);
    assign C         = c_r;
    assign Zero      = zero_r;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard testbench for alu_mc: expected results queued at accept, checked at consume.
`timescale 1ns/1ps
module tb_alu_mc;
    typedef struct {
        logic [31:0] c;
        int          lat;
        int          acc_edge;
    } exp_t;

    localparam logic [31:0] MIN_C  = 32'h8000_0000;
    localparam logic [31:0] ONES_C = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALUOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] C;
    logic        Zero;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    bit   prev_ov = 1'b0;
    bit   prev_cons = 1'b0;

    alu_mc #(.WIDTH(32), .OPW(5)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .Zero(Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_md(input logic [4:0] op);
`ifdef ALU_MULDIV_EN
        return (op >= 5'd16) && (op <= 5'd23);
`else
        return 1'b0;
`endif
    endfunction

    // Edges from the capture edge to the edge where out_valid rises.
    function automatic int lat_of(input logic [4:0] op);
        return is_md(op) ? 33 : 0;
    endfunction

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        up;
        logic signed [63:0] sp;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] sq;
        logic [31:0]        r;
        sa = a;
        sbv = b;
        up = 64'd0;
        sp = 64'sd0;
        sq = 32'sd0;
        case (op)
            5'd0:  r = b;
            5'd1:  r = a + b;
            5'd2:  r = a - b;
            5'd3:  r = a ^ b;
            5'd4:  r = a | b;
            5'd5:  r = a & b;
            5'd6:  r = a << b[4:0];
            5'd7:  r = a >> b[4:0];
            5'd8:  r = sa >>> b[4:0];
            5'd9:  r = (sa < sbv) ? 32'd1 : 32'd0;
            5'd10: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
            5'd16: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            5'd17: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
            5'd18: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = sp[63:32]; end
            5'd19: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            5'd20: begin
                if (b == 32'd0) r = ONES_C;
                else if (a == MIN_C && b == ONES_C) r = MIN_C;
                else begin sq = sa / sbv; r = sq; end
            end
            5'd21: r = (b == 32'd0) ? ONES_C : a / b;
            5'd22: begin
                if (b == 32'd0) r = a;
                else if (a == MIN_C && b == ONES_C) r = 32'd0;
                else begin sq = sa % sbv; r = sq; end
            end
            5'd23: r = (b == 32'd0) ? a : a % b;
`endif
            default: r = a;
        endcase
        return r;
    endfunction

    // Monitor: latency at first appearance, hold while stalled, value at consume, push at accept.
    always @(negedge clk) begin
        if (out_valid && (!prev_ov || prev_cons)) begin
            check_eq("pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check_eq("latency", 32'(edge_cnt - sb[0].acc_edge), 32'(sb[0].lat));
        end
        if (out_valid && !out_ready && sb.size() != 0) check_eq("hold_C", C, sb[0].c);
        if (out_valid && out_ready) begin
            check_eq("consume_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("C", C, mon_e.c);
                check_eq("Zero", 32'(Zero), 32'(mon_e.c == 32'd0));
            end
        end
        if (in_valid && in_ready) begin
            mon_e.c = model(ALUOp, A, B);
            mon_e.lat = lat_of(ALUOp);
            mon_e.acc_edge = edge_cnt + 1;
            sb.push_back(mon_e);
        end
        prev_ov = out_valid;
        prev_cons = out_valid && out_ready;
    end

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int waits);
        bit ok;
        ALUOp = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        waits = 0;
        ok = 1'b0;
        while (!ok && waits < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        check_eq("accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        ALUOp = 5'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    logic [4:0]  s_op[12] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd9, 5'd10, 5'd10, 5'd11, 5'd31};
    logic [31:0] s_a[12]  = '{32'h1234_5678, 32'hF0F0_F0F0, 32'h0F00_00F0, 32'hFF00_FF00, 32'h0000_0001,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0003,
                              32'hDEAD_BEEF, 32'hCAFE_F00D};
    logic [31:0] s_b[12]  = '{32'hABCD_E000, 32'h0FF0_0FF0, 32'h00F0_0F00, 32'h0FF0_0FF0, 32'h0000_003F,
                              32'h0000_0021, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0003,
                              32'h1111_1111, 32'h2222_2222};
    logic [4:0]  m_op[12] = '{5'd16, 5'd19, 5'd17, 5'd18, 5'd20, 5'd22, 5'd20, 5'd21, 5'd23, 5'd22,
                              5'd20, 5'd21};
    logic [31:0] m_a[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007,
                              32'h8000_0000, 32'h8000_0000, 32'h0000_0064, 32'h0000_0005, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] m_b[12]  = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000, 32'h0000_0002,
                              32'h0000_0002, 32'h0000_0001};

    initial begin
        int w;
        rstn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = 32'd0;
        B = 32'd0;
        ALUOp = 5'd0;
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_C", C, 32'd0);
        check_eq("rst_Zero", 32'(Zero), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        send(5'd1, 32'h7FFF_FFFF, 32'h0000_0001, w);
        check_eq("add_out_valid", 32'(out_valid), 32'd1);
        send(5'd2, 32'd5, 32'd5, w);
        check_eq("b2b_sub", 32'(w), 32'd1);
        send(5'd8, 32'hF000_0000, 32'h0000_0024, w);
        check_eq("b2b_sra", 32'(w), 32'd1);
        for (int i = 0; i < 12; i++) begin
            send(s_op[i], s_a[i], s_b[i], w);
            check_eq("b2b_simple", 32'(w), 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            send(5'($urandom_range(0, 15)), $urandom, $urandom, w);
        end
        drain();

        for (int i = 0; i < 12; i++) begin
            send(m_op[i], m_a[i], m_b[i], w);
        end
        for (int i = 0; i < 8; i++) begin
            send(5'($urandom_range(16, 23)), $urandom, (i == 3) ? 32'd0 : $urandom, w);
        end
        drain();

        out_ready = 1'b0;
        send(5'd1, 32'd3, 32'd4, w);
        repeat (5) @(posedge clk);
        #1;
        check_eq("stall_out_valid", 32'(out_valid), 32'd1);
        check_eq("stall_C", C, 32'd7);
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(5'd2, 32'd10, 32'd3, w);
        check_eq("same_edge_accept", 32'(w), 32'd1);
        drain();

        send(5'd20, 32'd100, 32'd7, w);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_C", C, 32'd0);
        check_eq("abort_Zero", 32'(Zero), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        send(5'd1, 32'd2, 32'd2, w);
        send(5'd21, 32'd50, 32'd5, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
